// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Watches a multiplexed active-low seven-segment scan bus and
//               rebuilds the displayed 8-digit hex word with a frame strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  num_csn,
    input  logic [7:0]  num_an,
    output logic [31:0] value,
    output logic [7:0]  dp,
    output logic [7:0]  blank,
    output logic        frame_valid,
    output logic        value_stable,
    output logic        decode_err
);

    localparam logic [CNT_W-1:0] c_settle = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero   = '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HELD   = 2'd2
    } state_t;

    // Input stage and one-cycle history used for the "unchanged" test
    logic [7:0]       r_csn;
    logic [7:0]       r_an;
    logic [7:0]       r_csn_d;
    logic [7:0]       r_an_d;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_mask;
    logic [31:0]      r_sh_value;
    logic [7:0]       r_sh_dp;
    logic [7:0]       r_sh_blank;
    logic             r_done;
    logic             r_have_frame;

    logic [31:0]      r_value;
    logic [7:0]       r_dp;
    logic [7:0]       r_blank;
    logic             r_frame_valid;
    logic             r_value_stable;
    logic             r_decode_err;

    logic [3:0]       w_zero_cnt;
    logic [2:0]       w_sel_idx;
    logic             w_sel_valid;
    logic [6:0]       w_seg;
    logic [3:0]       w_nib;
    logic             w_is_blank;
    logic             w_is_bad;
    logic             w_same;
    logic [CNT_W-1:0] w_cnt_inc;
    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_sample;
    logic [7:0]       w_bit;
    logic [7:0]       w_mask_new;
    logic             w_complete;

    // Digit select is valid only with exactly one low bit
    always_comb begin
        w_zero_cnt = 4'd0;
        w_sel_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!r_csn[i]) begin
                w_zero_cnt = w_zero_cnt + 4'd1;
                w_sel_idx  = 3'(i);
            end
        end
        w_sel_valid = (w_zero_cnt == 4'd1);
    end

    assign w_seg = ~r_an[6:0];

    always_comb begin
        w_nib      = 4'h0;
        w_is_blank = 1'b0;
        w_is_bad   = 1'b0;
        case (w_seg)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            7'h00: w_is_blank = 1'b1;
            default: w_is_bad = 1'b1;
        endcase
    end

    assign w_same    = (r_csn == r_csn_d) && (r_an == r_an_d);
    assign w_cnt_inc = r_cnt + c_one;

    // Dwell tracking: a fresh pair starts at count 1, so a one-cycle settle
    // samples on the very first cycle the pair is seen.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_sample     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sel_valid) begin
                    w_next_cnt = c_one;
                    if (c_one == c_settle) begin
                        w_sample     = 1'b1;
                        w_next_state = S_HELD;
                    end else begin
                        w_next_state = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (!w_sel_valid) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = c_zero;
                end else if (w_same) begin
                    w_next_cnt = w_cnt_inc;
                    if (w_cnt_inc == c_settle) begin
                        w_sample     = 1'b1;
                        w_next_state = S_HELD;
                    end
                end else begin
                    w_next_cnt = c_one;
                    if (c_one == c_settle) begin
                        w_sample     = 1'b1;
                        w_next_state = S_HELD;
                    end
                end
            end
            S_HELD: begin
                if (!w_sel_valid) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = c_zero;
                end else if (!w_same) begin
                    w_next_cnt = c_one;
                    if (c_one == c_settle) begin
                        w_sample = 1'b1;
                    end else begin
                        w_next_state = S_SETTLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = c_zero;
            end
        endcase
    end

    assign w_bit      = 8'h01 << w_sel_idx;
    assign w_mask_new = r_mask | w_bit;
    assign w_complete = w_sample && (w_mask_new == 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csn          <= 8'hFF;
            r_an           <= 8'hFF;
            r_csn_d        <= 8'hFF;
            r_an_d         <= 8'hFF;
            r_state        <= S_IDLE;
            r_cnt          <= c_zero;
            r_mask         <= 8'h00;
            r_sh_value     <= 32'h0;
            r_sh_dp        <= 8'h00;
            r_sh_blank     <= 8'h00;
            r_done         <= 1'b0;
            r_have_frame   <= 1'b0;
            r_value        <= 32'h0;
            r_dp           <= 8'h00;
            r_blank        <= 8'h00;
            r_frame_valid  <= 1'b0;
            r_value_stable <= 1'b0;
            r_decode_err   <= 1'b0;
        end else begin
            r_csn        <= num_csn;
            r_an         <= num_an;
            r_csn_d      <= r_csn;
            r_an_d       <= r_an;
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_decode_err <= w_sample && w_is_bad;
            r_done       <= w_complete;

            if (w_sample) begin
                r_sh_value[{w_sel_idx, 2'b00} +: 4] <= w_nib;
                r_sh_dp[w_sel_idx]                  <= ~r_an[7];
                r_sh_blank[w_sel_idx]               <= w_is_blank;
                // Shadow keeps the finished frame for one more edge; the mask
                // can restart immediately.
                r_mask <= w_complete ? 8'h00 : w_mask_new;
            end

            r_frame_valid <= r_done;
            if (r_done) begin
                r_value        <= r_sh_value;
                r_dp           <= r_sh_dp;
                r_blank        <= r_sh_blank;
                r_value_stable <= r_have_frame && (r_sh_value == r_value);
                r_have_frame   <= 1'b1;
            end
        end
    end

    assign value        = r_value;
    assign dp           = r_dp;
    assign blank        = r_blank;
    assign frame_valid  = r_frame_valid;
    assign value_stable = r_value_stable;
    assign decode_err   = r_decode_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_decoder
// Description : Directed, table-driven self-checking bench for seg_scan_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    localparam int SETTLE = 4;
    localparam int DWELL  = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  num_csn = 8'hFF;
    logic [7:0]  num_an = 8'hFF;
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic        frame_valid;
    logic        value_stable;
    logic        decode_err;

    seg_scan_decoder #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .num_csn     (num_csn),
        .num_an      (num_an),
        .value       (value),
        .dp          (dp),
        .blank       (blank),
        .frame_valid (frame_valid),
        .value_stable(value_stable),
        .decode_err  (decode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  dpm;
        logic [7:0]  blk;
        logic [31:0] exp_value;
        logic        exp_stable;
    } frame_t;

    frame_t     frames [5];
    logic [6:0] seg_tab [16];

    int cyc = 0;
    int fv_count = 0;
    int fv_cyc = -1;
    int err_count = 0;
    int err_cyc = -1;
    int checks = 0;
    int failures = 0;
    int last_apply = 0;
    int fv_before;
    int err_before;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters: a pulse wider than one cycle counts more than once
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_count = fv_count + 1;
            fv_cyc   = cyc;
        end
        if (decode_err === 1'b1) begin
            err_count = err_count + 1;
            err_cyc   = cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic scan_digit(input int d, input logic [3:0] nib, input logic dpl,
                              input logic blk, input int dwell);
        logic [7:0] sel;
        logic [6:0] seg;
        sel        = 8'h01 << d;
        seg        = blk ? 7'h00 : seg_tab[nib];
        num_csn    = ~sel;
        num_an     = ~{dpl, seg};
        last_apply = cyc;
        repeat (dwell) @(negedge clk);
    endtask

    task automatic idle(input int n);
        num_csn = 8'hFF;
        num_an  = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] ev, input logic [7:0] edp,
                               input logic [7:0] eblk, input logic est);
        check({tag, "_fv_count"}, 64'(fv_count), 64'(fv_before + 1));
        check({tag, "_fv_latency"}, 64'(fv_cyc), 64'(last_apply + SETTLE + 2));
        check({tag, "_value"}, 64'(value), 64'(ev));
        check({tag, "_dp"}, 64'(dp), 64'(edp));
        check({tag, "_blank"}, 64'(blank), 64'(eblk));
        check({tag, "_stable"}, 64'(value_stable), 64'(est));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
        seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
        seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C;
        seg_tab[12] = 7'h39; seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;

        frames[0] = '{32'h1234ABCD, 8'h08, 8'h00, 32'h1234ABCD, 1'b0};
        frames[1] = '{32'h89EF5670, 8'hA5, 8'h00, 32'h89EF5670, 1'b0};
        frames[2] = '{32'hCAFE0123, 8'h00, 8'h00, 32'hCAFE0123, 1'b0};
        frames[3] = '{32'hCAFE0123, 8'h00, 8'h00, 32'hCAFE0123, 1'b1};
        frames[4] = '{32'hCAFE0124, 8'h00, 8'h00, 32'hCAFE0124, 1'b0};

        // Reset held with the bus toggling valid-looking digits
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            num_csn = ~(8'h01 << i);
            num_an  = 8'($urandom);
            @(negedge clk);
            check("reset_outputs", 64'({value, dp, blank, frame_valid, value_stable, decode_err}), 64'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", 64'({value, dp, blank, frame_valid, value_stable, decode_err}), 64'h0);
        idle(4);
        check("reset_no_pulses", 64'(fv_count + err_count), 64'h0);

        // Full frames from the vector table
        for (int f = 0; f < 5; f++) begin
            fv_before  = fv_count;
            err_before = err_count;
            for (int d = 0; d < 8; d++)
                scan_digit(d, frames[f].word[4*d +: 4], frames[f].dpm[d], frames[f].blk[d], DWELL);
            idle(3);
            check_frame($sformatf("frame%0d", f), frames[f].exp_value, frames[f].dpm,
                        frames[f].blk, frames[f].exp_stable);
            check($sformatf("frame%0d_no_err", f), 64'(err_count), 64'(err_before));
        end

        // Digit 5 dwells too briefly: no frame until it is shown properly
        fv_before = fv_count;
        for (int d = 0; d < 8; d++)
            scan_digit(d, frames[0].word[4*d +: 4], 1'b0, 1'b0, (d == 5) ? 2 : DWELL);
        idle(3);
        check("short_dwell_no_frame", 64'(fv_count), 64'(fv_before));
        scan_digit(5, 4'h3, 1'b0, 1'b0, DWELL);
        idle(3);
        check_frame("short_dwell_fix", 32'h1234ABCD, 8'h00, 8'h00, 1'b0);

        // Two selects low must never sample; then an unknown glyph on digit 2
        fv_before  = fv_count;
        err_before = err_count;
        num_csn = 8'hFC;
        num_an  = ~8'h49;
        repeat (10) @(negedge clk);
        check("fc_no_sample", 64'(err_count), 64'(err_before));
        num_csn    = 8'hFB;
        num_an     = ~8'h49;
        last_apply = cyc;
        repeat (DWELL) @(negedge clk);
        check("bad_glyph_err_count", 64'(err_count), 64'(err_before + 1));
        check("bad_glyph_err_latency", 64'(err_cyc), 64'(last_apply + SETTLE + 1));
        for (int d = 0; d < 8; d++)
            if (d != 2) scan_digit(d, frames[0].word[4*d +: 4], 1'b0, 1'b0, DWELL);
        idle(3);
        check_frame("bad_glyph_frame", 32'h1234A0CD, 8'h00, 8'h00, 1'b0);
        check("bad_glyph_err_total", 64'(err_count), 64'(err_before + 1));

        // Reset after four captured digits throws the partial frame away
        fv_before = fv_count;
        for (int d = 0; d < 4; d++)
            scan_digit(d, 4'(d + 5), 1'b0, 1'b0, DWELL);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_value_cleared", 64'({value, blank, value_stable}), 64'h0);
        reset = 1'b0;
        for (int d = 4; d < 8; d++)
            scan_digit(d, 4'h0, 1'b0, 1'b1, DWELL);
        for (int d = 0; d < 4; d++)
            scan_digit(d, 4'h0, 1'b0, 1'b0, DWELL);
        idle(3);
        check_frame("midreset_frame", 32'h00000000, 8'h00, 8'hF0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reads the multiplexed seven-segment bus (num_csn / num_an) that the board top drives, and reconstructs the displayed 8-digit hex word.
- Used as an on-chip/in-bench display monitor: turns the scanned digit/segment stream back into a 32-bit value with a frame-complete strobe.
- Receiving end of the display driver's scan protocol.

Parameters:
- SETTLE_CYCLES, 4, consecutive cycles a digit-select/segment pair must be unchanged before it is sampled (>=1).
- CNT_W, 8, width of the dwell counter; SETTLE_CYCLES must be < 2^CNT_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- num_csn  in  8  digit select, active-low; bit i low selects digit i (digit 0 = least significant nibble).
- num_an  in  8  segment lines, active-low; bit0=a, bit1=b … bit6=g, bit7=dp.
- value  out  32  last complete frame; nibble i = digit i.
- dp  out  8  decimal-point state per digit from last complete frame (1 = lit).
- blank  out  8  per digit, 1 = digit was dark (no segments) in last frame.
- frame_valid  out  1  one-cycle pulse when value/dp/blank update.
- value_stable  out  1  1 when the last two completed frames had identical value.
- decode_err  out  1  one-cycle pulse on sampling an unrecognised segment pattern.

Behaviour:
- Reset: value=0, dp=0, blank=0, frame_valid=0, value_stable=0, decode_err=0; capture mask, shadow registers, dwell counter cleared; FSM to IDLE. Reset mid-frame discards the partial frame.
- Input stage: num_csn/num_an registered once (r_csn, r_an); all decisions use the registered pair.
- Valid select: r_csn has exactly one 0 bit. Any other value (all-ones, two or more low) is invalid.
- FSM:
  - IDLE: select invalid. On valid select -> SETTLE, cnt=1.
  - SETTLE: pair equal to previous cycle -> cnt+1; when cnt reaches SETTLE_CYCLES, sample, go HELD. Pair changes and still valid -> stay SETTLE, cnt=1. Select invalid -> IDLE.
  - HELD: exactly one sample per dwell. Pair change -> SETTLE (cnt=1) or IDLE if invalid.
- Decode of ~r_an[6:0] (gfedcba, active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - 00 = blank: nibble 0, blank bit set.
  - Any other pattern: nibble 0, blank bit clear, decode_err pulses on the cycle after the sample. The digit still counts as captured.
- Sample: write nibble, dp (=~r_an[7]) and blank into the shadow slot of the selected digit; set its mask bit. Re-sampling a digit before frame completion overwrites its slot.
- Frame completion: when the sample makes mask all-ones, on the next edge:
  - value/dp/blank load the shadow, including the new sample;
  - frame_valid pulses for 1 cycle;
  - mask clears;
  - value_stable <= (new value == previous value). The first frame after reset gives value_stable=0.
- Latency: a pair applied on num_* from edge k is sampled at edge k+SETTLE_CYCLES. The completing frame's outputs appear one edge later.
- Outputs hold between frames; frame_valid and decode_err never assert during reset.

Test Plan:
- Reset held 3 cycles, inputs toggling -> all outputs 0 throughout and 1 cycle after release.
- Scan digits 0..7 showing 0x1234ABCD (digit0 = D), 6 cycles each, dp lit on digit 3 only -> exactly one frame_valid pulse 1 cycle after digit 7's sample; value=32'h1234ABCD, dp=8'h08, blank=0, decode_err never.
- Same scan but digit 5 dwells only 2 cycles -> no frame_valid. A later full-dwell digit 5 -> frame_valid with correct value.
- num_csn=8'hFC for 10 cycles, then digit 2 with segments ~8'h49 -> no sample during FC; decode_err single pulse; nibble 2 = 0, blank[2]=0.
- Two identical frames 0xCAFE0123 -> value_stable 0 then 1. A third frame 0xCAFE0124 -> value_stable=0.
- Reset asserted after 4 digits captured, then full frame 0x00000000 with digits 4–7 blank -> single frame_valid after full 8-digit scan; value=0, blank=8'hF0.
